// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer / lock qualifier with retry and fault; PLL_LOSS_CNT_EN adds a lock-loss counter.
// Lock decisions lag pll_lock by 2 synchronizer cycles; no backpressure, all outputs registered.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int GLITCH_CYCLES = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [1:0] state_o,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int SW      = $clog2(STABLE_CYCLES + 1);
  localparam int GW      = $clog2(GLITCH_CYCLES + 1);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_stable;
  logic [GW-1:0] r_glitch;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_next;
  logic          r_sync1;
  logic          r_lock_s;
  logic          r_pll_reset;
  logic          r_ready;
  logic          r_fault;
  logic          w_stable_hit;
  logic          w_timeout;
  logic          w_glitch_hit;
  logic          w_loss;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // Stable threshold is checked before the timeout so it wins a same-cycle tie.
  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_stable_hit = r_lock_s && (r_stable == SW'(STABLE_CYCLES - 1));
    w_timeout    = (r_timer == TW'(LOCK_TIMEOUT - 1));
    w_glitch_hit = !r_lock_s && (r_glitch == GW'(GLITCH_CYCLES - 1));
    w_loss       = 1'b0;
    case (r_state)
      ST_RESET: begin
        if (r_timer == TW'(RST_CYCLES - 1)) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_stable_hit) begin
          w_next       = ST_LOCKED;
          w_retry_next = 4'd0;
        end else if (w_timeout) begin
          if (r_retry != 4'(MAX_RETRIES)) w_retry_next = r_retry + 4'd1;
          w_next = (w_retry_next == 4'(MAX_RETRIES)) ? ST_FAULT : ST_RESET;
        end
      end
      ST_LOCKED: begin
        if (w_glitch_hit) begin
          w_next = ST_RESET;
          w_loss = 1'b1;
        end
      end
      default: w_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_timer     <= '0;
      r_stable    <= '0;
      r_glitch    <= '0;
      r_retry     <= 4'd0;
      r_pll_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_state == ST_RESET || r_state == ST_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state == ST_WAIT && w_next == ST_WAIT && r_lock_s) begin
        r_stable <= r_stable + SW'(1);
      end else begin
        r_stable <= '0;
      end
      if (r_state == ST_LOCKED && w_next == ST_LOCKED && !r_lock_s) begin
        r_glitch <= r_glitch + GW'(1);
      end else begin
        r_glitch <= '0;
      end
      r_pll_reset <= (w_next == ST_RESET) || (w_next == ST_FAULT);
      r_ready     <= (w_next == ST_LOCKED);
      r_fault     <= (w_next == ST_FAULT);
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] r_loss;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_loss <= 8'd0;
    end else if (w_loss && r_loss != 8'hFF) begin
      r_loss <= r_loss + 8'd1;
    end
  end

  assign loss_cnt = r_loss;
`else
  logic w_loss_unused;
  assign w_loss_unused = w_loss;
  assign loss_cnt      = 8'd0;
`endif

  assign pll_reset = r_pll_reset;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: each scenario pushes the expected output transitions (cycle + values);
// a negedge monitor pops one entry per observed output change and compares.
module tb_pll_lock_supervisor;

  logic       clkin;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [1:0] state_o;
  logic [7:0] loss_cnt;

  localparam logic [1:0] S_RST = 2'b00, S_WAIT = 2'b01, S_LCK = 2'b10, S_FLT = 2'b11;

  typedef struct {
    int          cyc;
    logic [16:0] val;
  } ev_t;

  ev_t         ev_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_retry = 0;
  int          exp_loss = 0;
  logic [16:0] prev_snap = {S_RST, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};

  pll_lock_supervisor #(
    .RST_CYCLES(4), .STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .GLITCH_CYCLES(2), .MAX_RETRIES(3)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset), .ready(ready),
    .fault(fault), .retry_cnt(retry_cnt), .state_o(state_o), .loss_cnt(loss_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic [1:0] st, input logic prst, input logic rdy,
                         input logic flt);
    ev_t e;
    e.cyc = c;
    e.val = {st, prst, rdy, flt, exp_retry[3:0], exp_loss[7:0]};
    ev_q.push_back(e);
  endtask

  task automatic bump_loss();
`ifdef PLL_LOSS_CNT_EN
    if (exp_loss < 255) exp_loss++;
`endif
  endtask

  task automatic monitor();
    logic [16:0] snap;
    ev_t e;
    forever begin
      @(negedge clkin);
      snap = {state_o, pll_reset, ready, fault, retry_cnt, loss_cnt};
      if (snap !== prev_snap) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_change", 32'(snap), 32'(prev_snap));
        end else begin
          e = ev_q.pop_front();
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
          chk("evt_outputs", 32'(snap), 32'(e.val));
        end
        prev_snap = snap;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(S_RST));
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_loss"}, 32'(loss_cnt), 32'd0);
  endtask

  // Drop lock in LOCKED for `hold` cycles; expect loss, re-reset and relock.
  task automatic loss_relock(input int hold);
    int m;
    m = cyc;
    pll_lock = 1'b0;
    bump_loss();
    push_ev(m + 4, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(m + 8, S_WAIT, 1'b0, 1'b0, 1'b0);
    push_ev(m + 16, S_LCK, 1'b0, 1'b1, 1'b0);
    goto_cyc(m + hold);
    pll_lock = 1'b1;
    goto_cyc(m + 18);
  endtask

  initial begin
    int r, m, e;
    rst_n    = 1'b1;
    pll_lock = 1'b0;
    fork
      monitor();
    join_none
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    goto_cyc(3);

    // Release, then async reset in the middle of WAIT_LOCK.
    rst_n = 1'b1;
    r = cyc;
    push_ev(r + 4, S_WAIT, 1'b0, 1'b0, 1'b0);
    push_ev(r + 10, S_RST, 1'b1, 1'b0, 1'b0);
    goto_cyc(r + 10);
    rst_n = 1'b0;
    #1 chk_reset_outputs("wait_arst");
    goto_cyc(r + 12);
    rst_n = 1'b1;

    // Power-up lock 5 cycles after pll_reset falls.
    r = cyc;
    push_ev(r + 4, S_WAIT, 1'b0, 1'b0, 1'b0);
    push_ev(r + 19, S_LCK, 1'b0, 1'b1, 1'b0);
    goto_cyc(r + 9);
    pll_lock = 1'b1;
    goto_cyc(r + 25);

    // 1-cycle drop is ignored, 3-cycle drop is a loss.
    m = cyc;
    pll_lock = 1'b0;
    goto_cyc(m + 1);
    pll_lock = 1'b1;
    goto_cyc(m + 12);
    chk("glitch1_ready", 32'(ready), 32'd1);
    loss_relock(3);

    // Loss events (saturation when the counter is built, stays 0 otherwise).
    for (int i = 0; i < 300; i++) loss_relock(4);
    chk("loss_after_300", 32'(loss_cnt), 32'(exp_loss));

    // Toggling lock never qualifies; timeout then a stable/timeout tie.
    m = cyc;
    pll_lock = 1'b0;
    bump_loss();
    e = m + 8;
    push_ev(m + 4, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(e, S_WAIT, 1'b0, 1'b0, 1'b0);
    exp_retry = 1;
    push_ev(e + 32, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(e + 36, S_WAIT, 1'b0, 1'b0, 1'b0);
    exp_retry = 0;
    push_ev(e + 68, S_LCK, 1'b0, 1'b1, 1'b0);
    goto_cyc(e);
    for (int k = 0; k < 32; k++) begin
      pll_lock = ((k / 5) % 2) == 1;
      goto_cyc(e + k + 1);
    end
    pll_lock = 1'b0;
    goto_cyc(e + 36 + 22);
    pll_lock = 1'b1;
    goto_cyc(e + 76);
    chk("tie_retry", 32'(retry_cnt), 32'd0);

    // Lock lost for good: three timeouts to FAULT, which must hold.
    m = cyc;
    pll_lock = 1'b0;
    bump_loss();
    push_ev(m + 4, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(m + 8, S_WAIT, 1'b0, 1'b0, 1'b0);
    exp_retry = 1;
    push_ev(m + 40, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(m + 44, S_WAIT, 1'b0, 1'b0, 1'b0);
    exp_retry = 2;
    push_ev(m + 76, S_RST, 1'b1, 1'b0, 1'b0);
    push_ev(m + 80, S_WAIT, 1'b0, 1'b0, 1'b0);
    exp_retry = 3;
    push_ev(m + 112, S_FLT, 1'b1, 1'b0, 1'b1);
    goto_cyc(m + 1112);
    chk("fault_state", 32'(state_o), 32'(S_FLT));
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_pll_reset", 32'(pll_reset), 32'd1);
    chk("fault_retry", 32'(retry_cnt), 32'd3);

    // Async reset out of FAULT, then restart.
    exp_retry = 0;
    exp_loss  = 0;
    push_ev(cyc, S_RST, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk_reset_outputs("fault_arst");
    goto_cyc(cyc + 2);
    rst_n = 1'b1;
    r = cyc;
    push_ev(r + 4, S_WAIT, 1'b0, 1'b0, 1'b0);
    goto_cyc(r + 10);

    chk("pending_events", 32'(ev_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
